boot_mem: RTL

Unified instruction/data memory for the multicycle CPU, with a built-in byte-stream program loader. It sits directly downstream of the datapath's memory port (address, write data, read/write strobes) and feeds read data back for instruction fetch and loads. After reset it holds the CPU in reset, accepts a little-endian byte stream from the host/testbench over a valid/ready handshake, packs it into 32-bit words from address 0, then releases the CPU.

---
 rtl/boot_mem.sv | 130 +++++++++++++
 1 files changed

// File: rtl/boot_mem.sv
// Unified instruction/data memory with a byte-stream program loader
// that holds the CPU in reset until the image has been written.
module boot_mem #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_rst,
    output logic        loaded,
    output logic        err,
    input  logic [31:0] mem_adr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        LOAD,
        RELEASE,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     word_ptr_q, word_ptr_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [31:0]         asm_word_q, asm_word_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [31:0]         mem_wd;

    logic                accept;
    logic                commit;
    logic                overflow;
    logic [31:0]         merged;
    logic [ADDR_W-1:0]   cpu_idx;
    logic                unused_adr;

    assign cpu_idx    = mem_adr[ADDR_W+1:2];
    assign unused_adr = ^{mem_adr[31:ADDR_W+2], mem_adr[1:0]};

    assign ld_ready = (state_q == LOAD) && !rst;
    assign cpu_rst  = (state_q != RUN);
    assign loaded   = (state_q == RUN);
    assign err      = err_q;

    assign accept   = ld_valid & ld_ready;
    assign commit   = accept & ((byte_cnt_q == 2'd3) | ld_last);
    // Pointer saturates at DEPTH, so its MSB alone flags a full memory.
    assign overflow = word_ptr_q[ADDR_W];
    assign merged   = asm_word_q
                    | ({24'h0, ld_data} << {byte_cnt_q, 3'b000});

    always_comb begin
        state_d    = state_q;
        word_ptr_d = word_ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_word_d = asm_word_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_wa     = cpu_idx;
        mem_wd     = mem_wdata;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    asm_word_d = merged;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (commit) begin
                        asm_word_d = 32'h0;
                        byte_cnt_d = 2'd0;
                        if (overflow) begin
                            err_d = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            mem_wa     = word_ptr_q[ADDR_W-1:0];
                            mem_wd     = merged;
                            word_ptr_d = word_ptr_q + 1'b1;
                        end
                    end
                    if (ld_last) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                state_d = RUN;
            end
            RUN: begin
                mem_we = mem_write & ~rst;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            word_ptr_q <= '0;
            byte_cnt_q <= 2'd0;
            asm_word_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_ptr_q <= word_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_word_q <= asm_word_d;
            err_q      <= err_d;
        end
    end

    // Storage is deliberately left out of reset so images survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign mem_rdata = mem_read ? mem_q[cpu_idx] : 32'h0;

endmodule
